pad_monitor: RTL

Snoops the SNES A-bus to derive the joypad-related qualifiers `snes_ajr` and `pad_latch`, which the cheat/hook block consumes to pick its NMI-hook branch offsets. It sits directly upstream of that block, after the bus strobe generator. It tracks auto-joypad-read enable from $4200 writes. It also detects a complete manual latch-and-shift sequence on $4016 within each NMI-delimited frame and presents it as a per-frame flag.

---
 rtl/pad_monitor.sv | 114 +++++++++++
 1 files changed

// File: rtl/pad_monitor.sv
// SNES A-bus snooper: tracks auto-joypad-read enable and flags frames with a complete manual pad read.
// Optional build macro PAD_MONITOR_JOY2_EN: $4017 serial reads also advance the shared read counter.
module pad_monitor (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] SNES_ADDR,
    input  logic [7:0]  SNES_DATA,
    input  logic        SNES_wr_strobe,
    input  logic        SNES_rd_strobe,
    input  logic        SNES_cycle_start,
    input  logic        SNES_reset_strobe,
    output logic        snes_ajr,
    output logic        pad_latch,
    output logic [4:0]  pad_read_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        LATCH_HI,
        SHIFT,
        DONE
    } state_t;

    localparam logic [20:0] WD_MAX = 21'h1FFFFF;

    state_t      state;
    logic        frame_seen;
    logic [20:0] watchdog;

    logic io_bank;
    logic hit_4200;
    logic hit_4016;
    logic hit_4017;
    logic nmi_fetch;
    logic wd_reach;
    logic pad_rd;

    // Banks $00-$3F and $80-$BF mirror the I/O page; bit 22 separates them from ROM banks.
    assign io_bank   = ~SNES_ADDR[22];
    assign hit_4200  = io_bank && (SNES_ADDR[15:0] == 16'h4200);
    assign hit_4016  = io_bank && (SNES_ADDR[15:0] == 16'h4016);
    assign hit_4017  = io_bank && (SNES_ADDR[15:0] == 16'h4017);
    assign nmi_fetch = SNES_rd_strobe &&
                       ((SNES_ADDR == 24'h00FFEA) || (SNES_ADDR == 24'h00FFFA));
    assign wd_reach  = SNES_cycle_start && (watchdog == (WD_MAX - 21'd1));

`ifdef PAD_MONITOR_JOY2_EN
    assign pad_rd = SNES_rd_strobe && (hit_4016 || hit_4017);
`else
    assign pad_rd = SNES_rd_strobe && hit_4016;
`endif

    // Later assignments win, so a completing read in the saturation clock still sets frame_seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snes_ajr     <= 1'b0;
            pad_latch    <= 1'b0;
            pad_read_cnt <= 5'd0;
            state        <= IDLE;
            frame_seen   <= 1'b0;
            watchdog     <= 21'd0;
        end else if (SNES_reset_strobe) begin
            snes_ajr     <= 1'b0;
            pad_latch    <= 1'b0;
            pad_read_cnt <= 5'd0;
            state        <= IDLE;
            frame_seen   <= 1'b0;
            watchdog     <= 21'd0;
        end else if (nmi_fetch) begin
            pad_latch    <= frame_seen;
            frame_seen   <= 1'b0;
            state        <= IDLE;
            pad_read_cnt <= 5'd0;
            watchdog     <= 21'd0;
        end else begin
            if (SNES_cycle_start && (watchdog != WD_MAX)) begin
                watchdog <= watchdog + 21'd1;
            end
            if (wd_reach) begin
                pad_latch  <= 1'b0;
                frame_seen <= 1'b0;
            end
            if (SNES_wr_strobe && hit_4200) begin
                snes_ajr <= SNES_DATA[0];
            end
            if (SNES_wr_strobe && hit_4016) begin
                if (SNES_DATA[0]) begin
                    state        <= LATCH_HI;
                    pad_read_cnt <= 5'd0;
                end else if (state == LATCH_HI) begin
                    state <= SHIFT;
                end
            end
            if (pad_rd) begin
                case (state)
                    SHIFT: begin
                        pad_read_cnt <= pad_read_cnt + 5'd1;
                        if (pad_read_cnt == 5'd7) begin
                            state      <= DONE;
                            frame_seen <= 1'b1;
                        end
                    end
                    DONE: begin
                        if (pad_read_cnt != 5'd16) begin
                            pad_read_cnt <= pad_read_cnt + 5'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
